beep_drv: RTL and testbench

//   Output-side counterpart of the key debouncer: turns single-cycle event pulses
//   (debounced key presses, coin accepted, item vended) into timed buzzer/LED beeps.

---
 rtl/beep_drv.sv | 159 +++++++++++++++
 tb/tb_beep_drv.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/beep_drv.sv
// beep_drv: turns single-cycle event pulses into timed active-low buzzer/LED beeps,
// queueing events that arrive while a beep (or its trailing gap) is in progress.
// Latency: 1 cycle from pulse_in to out_n low; all outputs registered. Queue full -> event dropped, ovf pulse.
// Optional macro BEEP_TONE_EN: square-wave tone on out_n during ON (passive buzzers).
module beep_drv #(
  parameter int CNT_W     = 23,
  parameter int ON_CYC    = 4999999,
  parameter int GAP_CYC   = 2499999,
  parameter int PEND_W    = 3,
  parameter int TONE_HALF = 12499
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              out_n,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CNT_W-1:0]  ON_END   = CNT_W'(ON_CYC);
  localparam logic [CNT_W-1:0]  GAP_END  = CNT_W'(GAP_CYC);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_nxt;
  logic              out_nxt;
  logic              enq, deq, start;

  // Beep sequencing: decide next state, duration count, and whether an event is queued or replayed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    enq       = 1'b0;
    deq       = 1'b0;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pulse_in) begin
          state_nxt = S_ON;
          cnt_nxt   = '0;
          start     = 1'b1;
        end
      end
      S_ON: begin
        enq = pulse_in;
        if (cnt == ON_END) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_END) begin
          cnt_nxt = '0;
          if (pend_cnt != '0) begin
            // replay a queued beep; a pulse on this same edge takes its place in the queue
            state_nxt = S_ON;
            start     = 1'b1;
            deq       = 1'b1;
            enq       = pulse_in;
          end else if (pulse_in) begin
            state_nxt = S_ON;
            start     = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
          enq     = pulse_in;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pending-event queue depth: simultaneous enqueue and dequeue cancel out; full queue drops and flags.
  always_comb begin
    pend_nxt = pend_cnt;
    ovf_nxt  = 1'b0;
    if (enq && deq) begin
      pend_nxt = pend_cnt;
    end else if (deq) begin
      pend_nxt = pend_cnt - 1'b1;
    end else if (enq) begin
      if (pend_cnt == PEND_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        pend_nxt = pend_cnt + 1'b1;
      end
    end
  end

`ifdef BEEP_TONE_EN
  localparam int TW = $clog2(TONE_HALF + 2);
  localparam logic [TW-1:0] TONE_END = TW'(TONE_HALF);

  logic [TW-1:0] tone_cnt, tone_nxt;

  // Tone generator: restart low on every ON entry, toggle each TONE_HALF+1 cycles, silent outside ON.
  always_comb begin
    tone_nxt = tone_cnt;
    out_nxt  = 1'b1;
    if (start) begin
      tone_nxt = '0;
      out_nxt  = 1'b0;
    end else if (state == S_ON && state_nxt == S_ON) begin
      if (tone_cnt == TONE_END) begin
        tone_nxt = '0;
        out_nxt  = ~out_n;
      end else begin
        tone_nxt = tone_cnt + 1'b1;
        out_nxt  = out_n;
      end
    end
  end

  // Tone phase counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tone_cnt <= '0;
    else      tone_cnt <= tone_nxt;
  end
`else
  // Steady drive: pin low for the whole ON phase.
  always_comb begin
    out_nxt = (state_nxt != S_ON);
  end
`endif

  // State and output registers, all updated on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      out_n    <= 1'b1;
      busy     <= 1'b0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      out_n    <= out_nxt;
      busy     <= (state_nxt != S_IDLE);
      pend_cnt <= pend_nxt;
      ovf      <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_beep_drv.sv
// Testbench for beep_drv: directed scenarios plus random pulse traffic against a timeline model.
module tb_beep_drv;
  localparam int ON_CYC    = 9;
  localparam int GAP_CYC   = 4;
  localparam int PEND_W    = 2;
  localparam int TONE_HALF = 1;
  localparam int PERIOD    = ON_CYC + GAP_CYC + 2;
  localparam int QMAX      = (1 << PEND_W) - 1;
`ifdef BEEP_TONE_EN
  localparam int LOW_PER_BEEP = 6;
`else
  localparam int LOW_PER_BEEP = ON_CYC + 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pulse_in = 1'b0;
  logic              out_n, busy, ovf;
  logic [PEND_W-1:0] pend_cnt;

  beep_drv #(
    .CNT_W(4), .ON_CYC(ON_CYC), .GAP_CYC(GAP_CYC), .PEND_W(PEND_W), .TONE_HALF(TONE_HALF)
  ) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in),
    .out_n(out_n), .busy(busy), .pend_cnt(pend_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a beep is a PERIOD-long window; position t in the window says ON or GAP.
  bit m_act;
  int m_t;
  int m_q;
  bit m_ovf;
  int n_low, n_busy, n_ovf;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_out_n();
    if (!m_act || m_t > ON_CYC) return 1;
`ifdef BEEP_TONE_EN
    return ((m_t / (TONE_HALF + 1)) % 2 == 0) ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_act = 0; m_t = 0; m_q = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit p);
    m_ovf = 0;
    if (!m_act) begin
      if (p) begin m_act = 1; m_t = 0; end
    end else if (m_t == PERIOD - 1) begin
      if (m_q > 0) begin
        m_t = 0;
        if (!p) m_q--;
      end else if (p) begin
        m_t = 0;
      end else begin
        m_act = 0;
      end
    end else begin
      m_t++;
      if (p) begin
        if (m_q == QMAX) m_ovf = 1;
        else m_q++;
      end
    end
  endtask

  // One clock: drive pulse, advance model on the edge, compare all outputs just after it.
  task automatic step(input bit p);
    pulse_in = p;
    @(posedge clk);
    model_step(p);
    #1;
    check("out_n", int'(out_n), exp_out_n());
    check("busy", int'(busy), int'(m_act));
    check("pend_cnt", int'(pend_cnt), m_q);
    check("ovf", int'(ovf), int'(m_ovf));
    if (!out_n) n_low++;
    if (busy) n_busy++;
    if (ovf) n_ovf++;
  endtask

  task automatic clear_stats();
    n_low = 0; n_busy = 0; n_ovf = 0;
  endtask

  task automatic idle_until_quiet();
    int guard;
    guard = 0;
    while ((busy || m_act) && guard < 200) begin
      step(1'b0);
      guard++;
    end
    check("drain_timeout", guard < 200 ? 1 : 0, 1);
  endtask

  initial begin
    model_reset();
    clear_stats();
    #23;
    check("rst_out_n", int'(out_n), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_pend", int'(pend_cnt), 0);
    check("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b1;

    // single pulse from idle
    step(1'b0);
    clear_stats();
    step(1'b1);
    repeat (20) step(1'b0);
    check("single_low", n_low, LOW_PER_BEEP);
    check("single_busy", n_busy, PERIOD);

    // three pulses queued during the first beep
    clear_stats();
    step(1'b1);
    step(1'b1); check("q_pend1", int'(pend_cnt), 1);
    step(1'b1); check("q_pend2", int'(pend_cnt), 2);
    step(1'b1); check("q_pend3", int'(pend_cnt), 3);
    idle_until_quiet();
    check("q_low", n_low, 4 * LOW_PER_BEEP);
    check("q_busy", n_busy, 4 * PERIOD);

    // overflow: four pulses behind the first one
    clear_stats();
    step(1'b1);
    repeat (4) step(1'b1);
    check("ovf_pend", int'(pend_cnt), 3);
    check("ovf_count", n_ovf, 1);
    idle_until_quiet();
    check("ovf_low", n_low, 4 * LOW_PER_BEEP);

    // pulse on the GAP->ON edge with one queued
    step(1'b1);
    step(1'b1);
    repeat (PERIOD - 2) step(1'b0);
    step(1'b1);
    check("swap_pend", int'(pend_cnt), 1);
    check("swap_out_n", int'(out_n), 0);
    idle_until_quiet();

    // async reset in the middle of a beep, with a queued event
    step(1'b1);
    step(1'b1);
    repeat (2) step(1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_n", int'(out_n), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_pend", int'(pend_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
    end
    idle_until_quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
